mul_fu: RTL and testbench
=========================

Name: mul_fu

Overview:
- Functional unit at the consumer end of the issue-queue → FU control interface.
- Accepts one ready AArch64 MADD/MSUB instruction per transaction from its issue queue and computes it with an iterative shift-add multiplier.
- Drives the result onto the shared result bus: the peek broadcast that issue queues snoop, plus a completion tag for commit logic.
- Holds the result until the result-bus arbiter grants it.

Parameters:
- INST_ID_BITS, 6, instruction tag width
- PRN_BITS, 6, physical register number width
- BITS_PER_CYCLE, 4, multiplier bits retired per BUSY cycle; legal values 1, 2, 4, 8; elaboration error otherwise

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  issue-queue handshake; one-cycle pulse
- inst_id  in  INST_ID_BITS  instruction tag
- inst  in  32  raw instruction word
- op0  in  64  Rn value
- op1  in  64  Rm value
- op2  in  64  Ra value
- out_prn  in  PRN_BITS  destination PRN
- flush  in  1  kill in-flight work
- fu_ready  out  1  unit can accept this cycle
- result_valid  out  1  result offered to result bus
- result_grant  in  1  arbiter accepts offered result this cycle
- peek_prn  out  PRN_BITS  destination PRN of offered result
- peek_value  out  64  result value
- done_inst_id  out  INST_ID_BITS  tag of offered result

Behaviour:
- One clock domain, clk; rst_n is asynchronous, active-low.
- States:
  - IDLE: fu_ready=1.
  - BUSY: iterating.
  - DONE: result held.
- fu_ready = (state==IDLE). It is registered-state derived, no combinational path from inputs.
- Decode of inst, captured at accept:
  - sf = bit 31
  - o0 = bit 15: 0 = MADD, 1 = MSUB
  - Opcode field is not checked; only MADD/MSUB are routed to this unit.
  - Operand values are used as given. XZR substitution is upstream.
- Accept: inst_valid && fu_ready && !flush at a clock edge.
  - Latch tag, PRN, Rn, Rm, Ra, sf, o0.
  - Clear accumulator and step counter; go to BUSY.
  - inst_valid while not IDLE is ignored; the issue queue must not send.
- BUSY step (each edge):
  - partial = Rn × (low BITS_PER_CYCLE bits of remaining multiplier), shifted to the current position.
  - Add into 64-bit accumulator; shift multiplier right; counter +1.
  - Arithmetic is modulo 2^64.
- Step count N = 64/BITS_PER_CYCLE when sf=1, 32/BITS_PER_CYCLE when sf=0. For the default this is 16 or 8.
- On the edge completing step N, register the result and enter DONE:
  - MADD: Ra + product
  - MSUB: Ra − product
  - sf=0: low 32 bits of the result, zero-extended to 64.
- Latency: with the accept at edge t, result_valid is first high after edge t+N.
- DONE:
  - result_valid = (state==DONE) && !flush.
  - peek_prn, peek_value, done_inst_id stay stable while result_valid is high and not granted.
  - result_valid && result_grant at an edge → IDLE.
  - result_grant while result_valid is low is ignored.
  - No back-to-back acceptance: a new accept is possible at the earliest one edge after the grant.
- flush:
  - In any state, flush at an edge → IDLE.
  - In-flight result is discarded, no broadcast.
  - Flush wins over a simultaneous accept or grant.
- Reset:
  - Asynchronous; state=IDLE; accumulator, counter, and latched fields = 0.
  - Outputs: fu_ready=1 once rst_n deasserts (0 is not required during reset, but IDLE is forced); result_valid=0; peek_prn=0; peek_value=0; done_inst_id=0.
  - Reset mid-BUSY or mid-DONE discards the work; no result is emitted after release.
- Outputs while not in DONE: peek_prn, peek_value, done_inst_id hold their last values; consumers qualify with result_valid.

Test Plan:
- MADD 64-bit, inst=0x9B020C20, op0=3, op1=5, op2=7, inst_id=0x11, out_prn=0x2A, grant tied 1 → result_valid for exactly one cycle, 16 cycles after accept edge. Values: peek_value=22, peek_prn=0x2A, done_inst_id=0x11; fu_ready back to 1 the cycle after.
- MSUB 64-bit, inst=0x9B028C20, op0=0xFFFFFFFFFFFFFFFF, op1=2, op2=10 → peek_value=12, wraparound product −2.
- MADD 32-bit, inst=0x1B020C20, op0=0xFFFFFFFF, op1=0xFFFFFFFF, op2=0xFFFFFFFF00000000 → latency 8, peek_value=0x0000000000000001; upper half discarded, zero-extended.
- Backpressure: complete op with result_grant=0 for 5 cycles, then 1 → result_valid and payload stable all 6 cycles, fu_ready=0 throughout; inst_valid pulsed during the stall is ignored and its value never broadcast.
- Flush: flush at BUSY step 7 → IDLE next cycle, no result_valid ever; flush in DONE together with grant → result_valid=0 that cycle, no broadcast. Flush coincident with inst_valid → not accepted.
- Reset: rst_n low asynchronously (mid-clock) during BUSY → result_valid=0 and all payload outputs 0 immediately. After release: fu_ready=1, no result emitted; a fresh 3×5+7 op produces 22.

Source files
------------

// File: rtl/mul_fu.sv
// mul_fu: iterative shift-add MADD/MSUB unit that holds its result until the result bus grants it
module mul_fu #(
    parameter int INST_ID_BITS   = 6,
    parameter int PRN_BITS       = 6,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inst_valid,
    input  logic [INST_ID_BITS-1:0] inst_id,
    input  logic [31:0]             inst,
    input  logic [63:0]             op0,
    input  logic [63:0]             op1,
    input  logic [63:0]             op2,
    input  logic [PRN_BITS-1:0]     out_prn,
    input  logic                    flush,
    output logic                    fu_ready,
    output logic                    result_valid,
    input  logic                    result_grant,
    output logic [PRN_BITS-1:0]     peek_prn,
    output logic [63:0]             peek_value,
    output logic [INST_ID_BITS-1:0] done_inst_id
);
    localparam int B = BITS_PER_CYCLE;
    if (!(B == 1 || B == 2 || B == 4 || B == 8)) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [INST_ID_BITS-1:0] tag;
    logic [PRN_BITS-1:0] prn;
    logic [63:0] mcand, mplier, ra, acc, acc_n, res;
    logic [6:0] cnt;
    logic sf, o0, last, accept;
    assign fu_ready     = state == IDLE;
    assign result_valid = state == DONE && !flush;
    assign accept       = state == IDLE && inst_valid && !flush;
    assign last         = cnt == (sf ? 7'(64 / B - 1) : 7'(32 / B - 1));
    always_comb begin
        acc_n = acc + mcand * 64'(mplier[B-1:0]);
        res   = o0 ? ra - acc_n : ra + acc_n;
        state_n = flush ? IDLE
                : accept ? BUSY
                : (state == BUSY && last) ? DONE
                : (state == DONE && result_grant) ? IDLE
                : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {tag, prn, mcand, mplier, ra, sf, o0, acc, cnt} <= '0;
            {peek_prn, peek_value, done_inst_id} <= '0;
        end else if (accept) begin
            tag    <= inst_id;
            prn    <= out_prn;
            mcand  <= op0;
            mplier <= op1;
            ra     <= op2;
            sf     <= inst[31];
            o0     <= inst[15];
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY && !flush) begin
            acc    <= acc_n;
            mcand  <= mcand << B;
            mplier <= mplier >> B;
            cnt    <= cnt + 7'd1;
            if (last) begin
                peek_value   <= sf ? res : {32'b0, res[31:0]};
                peek_prn     <= prn;
                done_inst_id <= tag;
            end
        end
    end
endmodule

// File: tb/tb_mul_fu.sv
// tb_mul_fu: directed vectors with a result-bus scoreboard for mul_fu
module tb_mul_fu;
    logic clk, rst_n, inst_valid, flush, fu_ready, result_valid, result_grant;
    logic [5:0] inst_id, out_prn, peek_prn, done_inst_id;
    logic [31:0] inst;
    logic [63:0] op0, op1, op2, peek_value;
    typedef struct packed {
        logic [5:0]  prn;
        logic [5:0]  id;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];
    int n_vec, n_err;

    mul_fu dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_id(inst_id), .inst(inst),
        .op0(op0), .op1(op1), .op2(op2), .out_prn(out_prn), .flush(flush), .fu_ready(fu_ready),
        .result_valid(result_valid), .result_grant(result_grant), .peek_prn(peek_prn),
        .peek_value(peek_value), .done_inst_id(done_inst_id)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000ns");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // scoreboard monitor: every offered result must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got value 0x%0h id 0x%0h expected no broadcast",
                         peek_value, done_inst_id);
            end else begin
                check("peek_value", peek_value, sb[0].val);
                check("peek_prn", 64'(peek_prn), 64'(sb[0].prn));
                check("done_inst_id", 64'(done_inst_id), 64'(sb[0].id));
                if (result_grant) void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [5:0] id, input logic [5:0] prn,
                         input bit expect_res, input logic [63:0] val);
        inst = i; op0 = a; op1 = b; op2 = c; inst_id = id; out_prn = prn; inst_valid = 1;
        if (expect_res) sb.push_back('{prn: prn, id: id, val: val});
        @(posedge clk);
        #1 inst_valid = 0;
    endtask

    task automatic wait_result(input int n, input string name);
        int lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!result_valid && lat < 100);
        check(name, 64'(lat), 64'(n));
    endtask

    task automatic run_op(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [5:0] id, input logic [5:0] prn,
                          input logic [63:0] val, input int n);
        issue(i, a, b, c, id, prn, 1, val);
        wait_result(n, "latency");
        @(negedge clk);
        check("one_cycle_valid", 64'(result_valid), 0);
        check("ready_after_grant", 64'(fu_ready), 1);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 0; inst_valid = 0; flush = 0; result_grant = 1;
        inst = 0; op0 = 0; op1 = 0; op2 = 0; inst_id = 0; out_prn = 0;
        #12;
        check("reset_valid", 64'(result_valid), 0);
        check("reset_value", peek_value, 0);
        check("reset_prn", 64'(peek_prn), 0);
        check("reset_id", 64'(done_inst_id), 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("ready_after_reset", 64'(fu_ready), 1);

        run_op(32'h9B020C20, 3, 5, 7, 6'h11, 6'h2A, 22, 16);
        run_op(32'h9B028C20, 64'hFFFFFFFFFFFFFFFF, 2, 10, 6'h12, 6'h05, 12, 16);
        run_op(32'h1B020C20, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF00000000, 6'h13, 6'h06, 1, 8);
        run_op(32'h1B028C20, 5, 3, 10, 6'h14, 6'h07, 64'h00000000FFFFFFFB, 8);
        run_op(32'h9B020C20, 64'h123456789, 16, 0, 6'h15, 6'h08, 64'h1234567890, 16);

        // backpressure: five ungranted cycles, then grant on the sixth
        result_grant = 0;
        issue(32'h9B020C20, 6, 7, 1, 6'h21, 6'h31, 1, 43);
        wait_result(16, "latency_bp");
        check("bp_ready", 64'(fu_ready), 0);
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                inst = 32'h9B020C20; op0 = 100; op1 = 100; op2 = 100;
                inst_id = 6'h3F; out_prn = 6'h3F; inst_valid = 1;
            end
            if (k == 3) inst_valid = 0;
            @(negedge clk);
            check("bp_valid", 64'(result_valid), 1);
            check("bp_ready", 64'(fu_ready), 0);
        end
        @(posedge clk);
        #1 result_grant = 1;
        @(negedge clk);
        check("bp_valid_grant", 64'(result_valid), 1);
        @(negedge clk);
        check("bp_released", 64'(result_valid), 0);
        check("bp_ready_after", 64'(fu_ready), 1);
        repeat (20) @(negedge clk);

        // flush during BUSY step 7
        issue(32'h9B020C20, 9, 9, 9, 6'h22, 6'h32, 0, 0);
        repeat (6) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        check("flush_busy_idle", 64'(fu_ready), 1);
        repeat (25) @(negedge clk);

        // flush on the first DONE cycle with grant high
        issue(32'h9B020C20, 4, 4, 4, 6'h25, 6'h35, 0, 0);
        repeat (16) @(posedge clk);
        #1 flush = 1;
        @(negedge clk);
        check("flush_done_valid", 64'(result_valid), 0);
        check("flush_done_state", 64'(fu_ready), 0);
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        check("flush_done_idle", 64'(fu_ready), 1);
        repeat (25) @(negedge clk);

        // flush coincident with inst_valid blocks the accept
        inst = 32'h9B020C20; op0 = 1; op1 = 1; op2 = 1; inst_id = 6'h26; out_prn = 6'h36;
        inst_valid = 1; flush = 1;
        @(posedge clk);
        #1 inst_valid = 0; flush = 0;
        @(negedge clk);
        check("flush_accept_blocked", 64'(fu_ready), 1);
        repeat (25) @(negedge clk);

        // asynchronous reset mid-BUSY
        issue(32'h9B020C20, 2, 2, 2, 6'h23, 6'h33, 0, 0);
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("async_rst_valid", 64'(result_valid), 0);
        check("async_rst_value", peek_value, 0);
        check("async_rst_prn", 64'(peek_prn), 0);
        check("async_rst_id", 64'(done_inst_id), 0);
        @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("ready_after_async_rst", 64'(fu_ready), 1);
        repeat (30) @(negedge clk);
        run_op(32'h9B020C20, 3, 5, 7, 6'h24, 6'h34, 22, 16);

        repeat (5) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
